// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// FSM state encoding and default operand width.
package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned DefWidth = 8;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages.
// Purely combinational; reused once per cycle by serial_adder.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;
   logic g1;
   logic g2;

   assign p  = x ^ y;
   assign g1 = x & y;
   assign s  = p ^ ci;
   assign g2 = p & ci;
   assign co = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder with start/busy/done handshake.
// One full-adder cell is time-shared across all WIDTH bit positions.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DefWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] ps_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_q;
   logic             cout_q;
   logic             done_q;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] ps_d;
   logic             last;

   fa_cell u_fa (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign ps_d = {fa_s, ps_q[WIDTH-1:1]};
   assign last = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ps_q    <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  c_q     <= cin;
                  cnt_q   <= '0;
                  ps_q    <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               ps_q  <= ps_d;
               c_q   <= fa_co;
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + 1'b1;
               // Last bit: publish result straight from the cell outputs
               if (last) begin
                  state_q <= IDLE;
                  sum_q   <= ps_d;
                  cout_q  <= fa_co;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=2).
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   logic       start2;
   logic [1:0] a2;
   logic [1:0] b2;
   logic       cin2;
   logic       busy2;
   logic       done2;
   logic [1:0] sum2;
   logic       cout2;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] held   = 8'h00;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .cin   (cin2),
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .cout  (cout2)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic logic [8:0] ref8(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic c);
      return {1'b0, x} + {1'b0, y} + {8'd0, c};
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic go(input logic [7:0] x, input logic [7:0] y,
                     input logic c);
      a     = x;
      b     = y;
      cin   = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_add(input string tag,
                             input logic [8:0] exp,
                             input int inj,
                             input bit b2b,
                             input logic [7:0] nx,
                             input logic [7:0] ny,
                             input logic nc);
      int nbusy  = 0;
      bit stable = 1'b1;
      for (int t = 0; t < 20 && !done; t++) begin
         nbusy += int'(busy);
         if (sum !== held) stable = 1'b0;
         if (t == inj) begin
            start = 1'b1;
            a     = 8'h01;
            b     = 8'h01;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, " busy_cycles"}, nbusy, 8);
      check({tag, " sum_hold"}, 32'(stable), 1);
      check({tag, " done"}, 32'(done), 1);
      check({tag, " sum"}, 32'(sum), 32'(exp[7:0]));
      check({tag, " cout"}, 32'(cout), 32'(exp[8]));
      check({tag, " busy_end"}, 32'(busy), 0);
      held = exp[7:0];
      if (b2b) begin
         a     = nx;
         b     = ny;
         cin   = nc;
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, " done_clr"}, 32'(done), 0);
      check({tag, " sum_keep"}, 32'(sum), 32'(held));
   endtask

   initial begin
      logic [7:0] x, y, nx, ny;
      logic       c, nc;
      bit         pend;
      bit         bb;
      bit         quiet;
      int         nb2;

      rst    = 1'b1;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      cin    = 1'b0;
      start2 = 1'b0;
      a2     = '0;
      b2     = '0;
      cin2   = 1'b0;
      #12;
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst sum", 32'(sum), 0);
      check("rst cout", 32'(cout), 0);
      @(negedge clk);
      rst = 1'b0;

      go(8'h5A, 8'h33, 1'b0);
      finish_add("basic", ref8(8'h5A, 8'h33, 1'b0), -1, 0, 0, 0, 0);
      check("basic lit", 32'(held), 32'h8D);

      go(8'hFF, 8'h01, 1'b0);
      finish_add("ovf1", ref8(8'hFF, 8'h01, 1'b0), -1, 0, 0, 0, 0);
      check("ovf1 lit", 32'(cout), 1);
      go(8'hFF, 8'h00, 1'b1);
      finish_add("ovf2", ref8(8'hFF, 8'h00, 1'b1), -1, 0, 0, 0, 0);

      go(8'h10, 8'h20, 1'b0);
      finish_add("ign", ref8(8'h10, 8'h20, 1'b0), 3, 0, 0, 0, 0);
      quiet = 1'b1;
      repeat (12) begin
         if (busy || done) quiet = 1'b0;
         @(negedge clk);
      end
      check("ign no_relaunch", 32'(quiet), 1);

      go(8'h5A, 8'h33, 1'b0);
      finish_add("b2b1", ref8(8'h5A, 8'h33, 1'b0), -1, 1,
                 8'h80, 8'h80, 1'b1);
      finish_add("b2b2", ref8(8'h80, 8'h80, 1'b1), -1, 0, 0, 0, 0);
      check("b2b2 lit", 32'(held), 32'h01);

      go(8'hF0, 8'h0F, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst busy", 32'(busy), 0);
      check("mid_rst done", 32'(done), 0);
      check("mid_rst sum", 32'(sum), 0);
      check("mid_rst cout", 32'(cout), 0);
      @(negedge clk);
      rst  = 1'b0;
      held = 8'h00;
      quiet = 1'b1;
      repeat (12) begin
         if (busy || done) quiet = 1'b0;
         @(negedge clk);
      end
      check("mid_rst no_done", 32'(quiet), 1);
      go(8'h01, 8'h02, 1'b0);
      finish_add("post_rst", ref8(8'h01, 8'h02, 1'b0), -1, 0, 0, 0, 0);

      pend = 1'b0;
      x = '0; y = '0; c = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (!pend) begin
            x = 8'($urandom);
            y = 8'($urandom);
            c = 1'($urandom);
            go(x, y, c);
         end
         nx = 8'($urandom);
         ny = 8'($urandom);
         nc = 1'($urandom);
         bb = (i < 23) ? 1'($urandom) : 1'b0;
         finish_add("rnd", ref8(x, y, c), -1, bb, nx, ny, nc);
         x = nx; y = ny; c = nc;
         pend = bb;
      end

      a2     = 2'b11;
      b2     = 2'b11;
      cin2   = 1'b1;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      nb2 = 0;
      for (int t = 0; t < 10 && !done2; t++) begin
         nb2 += int'(busy2);
         @(negedge clk);
      end
      check("w2 busy_cycles", nb2, 2);
      check("w2 done", 32'(done2), 1);
      check("w2 sum", 32'(sum2), 32'h3);
      check("w2 cout", 32'(cout2), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
